// File: rtl/booth_mul_iter_if.sv
// Operand/result handshake bundle for booth_mul_iter: issue-side valid/ready
// with operands, writeback-side valid/ready with the two product halves.
interface booth_mul_iter_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic            mulw;
    logic [1:0]      mul_signed;
    logic [XLEN-1:0] multiplicand;
    logic [XLEN-1:0] multiplier;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result_hi;
    logic [XLEN-1:0] result_lo;

    modport master (
        output in_valid, mulw, mul_signed, multiplicand, multiplier, out_ready,
        input  in_ready, out_valid, result_hi, result_lo
    );

    modport slave (
        input  in_valid, mulw, mul_signed, multiplicand, multiplier, out_ready,
        output in_ready, out_valid, result_hi, result_lo
    );
endinterface

// File: rtl/booth_mul_iter.sv
// Iterative radix-4 Booth multiplier, DPC digits per cycle, with W mode and flush.
// Optional macro EARLY_TERM_EN: leave BUSY once the remaining multiplier digits are all zero.
//
// state | meaning
// IDLE  | waiting for operands (in_ready high unless flushing)
// BUSY  | retiring DPC Booth digits per cycle into the accumulator
// DONE  | first cycle registers the result, then holds it until out_ready
module booth_mul_iter #(
    parameter int XLEN = 64,
    parameter int DPC  = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    booth_mul_iter_if.slave   bus
);
    localparam int W      = XLEN / 2;
    localparam int AW     = 2 * XLEN + 2;
    localparam int BW     = XLEN + 2;
    localparam int SH     = 2 * DPC;
    localparam int D_FULL = (XLEN + 2) / 2;
    localparam int D_HALF = (W + 2) / 2;
    localparam int C_FULL = (D_FULL + DPC - 1) / DPC;
    localparam int C_HALF = (D_HALF + DPC - 1) / DPC;
    localparam int CW     = $clog2(C_FULL + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_a;
    logic [AW-1:0]   r_acc;
    logic [BW-1:0]   r_b;
    logic [CW-1:0]   r_cnt;
    logic            r_mulw;
    logic            r_out_valid;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;

    logic [AW-1:0]   w_a_ext;
    logic [BW-1:0]   w_b_ext;
    logic [AW-1:0]   w_sum;
    logic [BW-1:0]   w_b_nxt;
    logic [XLEN-1:0] w_hi;
    logic [XLEN-1:0] w_lo;
    logic            w_accept;
    logic            w_fire;
    logic            w_last;
    logic            w_unused_acc_top;

    assign bus.in_ready  = (r_state == IDLE) & ~flush;
    assign bus.out_valid = r_out_valid;
    assign bus.result_hi = r_hi;
    assign bus.result_lo = r_lo;

    assign w_accept = bus.in_valid & bus.in_ready;
    assign w_fire   = r_out_valid & bus.out_ready;
    assign w_b_nxt  = {{SH{r_b[BW-1]}}, r_b[BW-1:SH]};
    assign w_unused_acc_top = ^r_acc[AW-1:2*XLEN];

`ifdef EARLY_TERM_EN
    // All-0 or all-1 remaining bits (overlap bit included) recode to zero digits only.
    assign w_last = (r_cnt == '0) | (w_b_nxt == '0) | (&w_b_nxt);
`else
    assign w_last = (r_cnt == '0);
`endif

    always_comb begin
        w_a_ext = '0;
        w_b_ext = '0;
        if (bus.mulw) begin
            w_a_ext = {{(AW-W){bus.mul_signed[1] & bus.multiplicand[W-1]}},
                       bus.multiplicand[W-1:0]};
            w_b_ext = {{(BW-W-1){bus.mul_signed[0] & bus.multiplier[W-1]}},
                       bus.multiplier[W-1:0], 1'b0};
        end else begin
            w_a_ext = {{(AW-XLEN){bus.mul_signed[1] & bus.multiplicand[XLEN-1]}},
                       bus.multiplicand};
            w_b_ext = {{(BW-XLEN-1){bus.mul_signed[0] & bus.multiplier[XLEN-1]}},
                       bus.multiplier, 1'b0};
        end
    end

    // r_a is pre-shifted each cycle, so digit j only needs a fixed 2*j offset.
    always_comb begin
        w_sum = r_acc;
        for (int j = 0; j < DPC; j++) begin
            case (r_b[2*j +: 3])
                3'b001, 3'b010: w_sum = w_sum + (r_a << (2*j));
                3'b011:         w_sum = w_sum + (r_a << (2*j + 1));
                3'b100:         w_sum = w_sum - (r_a << (2*j + 1));
                3'b101, 3'b110: w_sum = w_sum - (r_a << (2*j));
                default:        w_sum = w_sum;
            endcase
        end
    end

    always_comb begin
        w_hi = r_acc[2*XLEN-1:XLEN];
        w_lo = r_acc[XLEN-1:0];
        if (r_mulw) begin
            w_hi = {{(XLEN-W){r_acc[2*W-1]}}, r_acc[2*W-1:W]};
            w_lo = {{(XLEN-W){r_acc[W-1]}}, r_acc[W-1:0]};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = BUSY;
            BUSY:    if (w_last)   w_state_nxt = DONE;
            DONE:    if (w_fire)   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (flush) w_state_nxt = IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_mulw      <= 1'b0;
            r_out_valid <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
        end else if (flush) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a    <= w_a_ext;
                        r_b    <= w_b_ext;
                        r_acc  <= '0;
                        r_mulw <= bus.mulw;
                        r_cnt  <= bus.mulw ? CW'(C_HALF - 1) : CW'(C_FULL - 1);
                    end
                end
                BUSY: begin
                    r_acc <= w_sum;
                    r_a   <= r_a << SH;
                    r_b   <= w_b_nxt;
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                end
                DONE: begin
                    if (w_fire) begin
                        r_out_valid <= 1'b0;
                        r_hi        <= '0;
                        r_lo        <= '0;
                    end else if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_hi        <= w_hi;
                        r_lo        <= w_lo;
                    end
                end
                default: r_out_valid <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_mul_iter.sv
// Scoreboard bench for booth_mul_iter: directed operands push expected products,
// a monitor pops and compares on each output handshake, including latency.
module tb_booth_mul_iter;
    localparam int XLEN  = 64;
    localparam int DPC   = 1;
    localparam int LAT_F = (DPC == 1) ? 34 : 18;
    localparam int LAT_W = (DPC == 1) ? 18 : 10;

    typedef struct {
        string       name;
        logic [63:0] hi;
        logic [63:0] lo;
        int          acc;
        int          lat;
        bit          chk;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    logic flush;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   rises = 0;
    int   rise_cyc = 0;
    bit   prev_valid = 1'b0;
    exp_t sb[$];

    booth_mul_iter_if #(.XLEN(XLEN)) bus ();

    booth_mul_iter #(.XLEN(XLEN), .DPC(DPC)) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%016h required=0x%016h", nm, act, req);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        int   lat;
        #2;
        if (bus.out_valid && !prev_valid) begin
            rises++;
            rise_cyc = cyc;
        end
        checks++;
        if (!bus.out_valid && (bus.result_hi !== 64'h0 || bus.result_lo !== 64'h0)) begin
            failures++;
            $display("FAIL zero_when_invalid actual hi=0x%016h lo=0x%016h required 0",
                     bus.result_hi, bus.result_lo);
        end
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual out_valid=1 required none pending");
            end else begin
                e = sb.pop_front();
                lat = rise_cyc - e.acc;
                if (e.chk) begin
                    chk({e.name, "_hi"}, bus.result_hi, e.hi);
                    chk({e.name, "_lo"}, bus.result_lo, e.lo);
                end
                checks++;
`ifdef EARLY_TERM_EN
                if (lat < 2 || lat > e.lat) begin
`else
                if (lat != e.lat) begin
`endif
                    failures++;
                    $display("FAIL %s_latency actual=%0d required=%0d", e.name, lat, e.lat);
                end
            end
        end
        prev_valid = bus.out_valid;
    end

    task automatic issue(input string nm, input bit w, input logic [1:0] s,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] ehi, input logic [63:0] elo,
                         input bit expect_out, input bit chk_val);
        exp_t e;
        int   n;
        @(negedge clock);
        bus.mulw         = w;
        bus.mul_signed   = s;
        bus.multiplicand = a;
        bus.multiplier   = b;
        bus.in_valid     = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            failures++;
            $display("FAIL %s_accept_timeout actual in_ready=0 required 1", nm);
            bus.in_valid = 1'b0;
            return;
        end
        if (expect_out) begin
            e.name = nm; e.hi = ehi; e.lo = elo; e.acc = cyc + 1;
            e.lat = w ? LAT_W : LAT_F; e.chk = chk_val;
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
        bus.in_valid     = 1'b0;
        bus.multiplicand = 64'hA5A5_5A5A_DEAD_BEEF;
        bus.multiplier   = 64'h0123_4567_89AB_CDEF;
        bus.mulw         = ~w;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout actual pending=%0d required 0", sb.size());
        end
    endtask

    initial begin
        int n;
        int r0;
        reset = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.mulw = 1'b0;
        bus.mul_signed = 2'b00;
        bus.multiplicand = '0;
        bus.multiplier = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("reset_in_ready", {63'h0, bus.in_ready}, 64'h1);
        chk("reset_out_valid", {63'h0, bus.out_valid}, 64'h0);
        chk("reset_hi", bus.result_hi, 64'h0);
        chk("reset_lo", bus.result_lo, 64'h0);

        issue("ss_m3x7", 1'b0, 2'b11, -64'sd3, 64'd7,
              64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFEB, 1'b1, 1'b1);
        issue("uu_max", 1'b0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001, 1'b1, 1'b1);
        issue("su_m1xmax", 1'b0, 2'b10, -64'sd1, 64'hFFFF_FFFF_FFFF_FFFF,
              64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b1, 1'b1);
        issue("w_ss_min2", 1'b1, 2'b11, 64'h0000_0001_8000_0000, 64'd2,
              64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b1);
        issue("w_uu", 1'b1, 2'b00, 64'h0000_0000_FFFF_FFFF, 64'd2,
              64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1);
        issue("w_ss_garbage", 1'b1, 2'b11, 64'hDEAD_BEEF_0000_0007, 64'h1234_5678_FFFF_FFFD,
              64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFEB, 1'b1, 1'b1);
        issue("ss_maxx2", 1'b0, 2'b11, 64'h7FFF_FFFF_FFFF_FFFF, 64'd2,
              64'h0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1);
        issue("illegal01", 1'b0, 2'b01, 64'd9, -64'sd9, 64'h0, 64'h0, 1'b1, 1'b0);
        drain();

        // Hold the result with out_ready low, then release into a back-to-back op.
        bus.out_ready = 1'b0;
        issue("hold_3x4", 1'b0, 2'b00, 64'd3, 64'd4, 64'h0, 64'd12, 1'b1, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clock);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("hold_out_valid", {63'h0, bus.out_valid}, 64'h1);
            chk("hold_in_ready", {63'h0, bus.in_ready}, 64'h0);
            chk("hold_hi", bus.result_hi, 64'h0);
            chk("hold_lo", bus.result_lo, 64'd12);
        end
        bus.out_ready = 1'b1;
        @(negedge clock);
        chk("release_out_valid", {63'h0, bus.out_valid}, 64'h0);
        chk("release_in_ready", {63'h0, bus.in_ready}, 64'h1);
        issue("b2b_5x6", 1'b0, 2'b11, 64'd5, 64'd6, 64'h0, 64'd30, 1'b1, 1'b1);
        drain();

        // Flush on the 10th BUSY cycle.
        r0 = rises;
        issue("flushed", 1'b0, 2'b11, 64'd100, 64'd100, 64'h0, 64'h0, 1'b0, 1'b0);
        repeat (9) @(posedge clock);
        @(negedge clock);
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        @(negedge clock);
        chk("flush_in_ready", {63'h0, bus.in_ready}, 64'h1);
        repeat (40) @(negedge clock);
        chk("flush_no_output", 64'(rises - r0), 64'h0);

        // Reset on the 5th BUSY cycle.
        issue("reset_abort", 1'b0, 2'b11, 64'd77, 64'd77, 64'h0, 64'h0, 1'b0, 1'b0);
        repeat (4) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("mid_reset_out_valid", {63'h0, bus.out_valid}, 64'h0);
        chk("mid_reset_hi", bus.result_hi, 64'h0);
        chk("mid_reset_lo", bus.result_lo, 64'h0);
        chk("mid_reset_in_ready", {63'h0, bus.in_ready}, 64'h1);
        repeat (40) @(negedge clock);
        chk("reset_no_output", 64'(rises - r0), 64'h0);

        // flush beats in_valid in IDLE.
        @(negedge clock);
        bus.in_valid = 1'b1;
        flush = 1'b1;
        #1;
        chk("flush_idle_in_ready", {63'h0, bus.in_ready}, 64'h0);
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        flush = 1'b0;
        repeat (40) @(negedge clock);
        chk("flush_idle_no_output", 64'(rises - r0), 64'h0);

        issue("after_12xm4", 1'b0, 2'b11, 64'd12, -64'sd4,
              64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFD0, 1'b1, 1'b1);
        drain();
        repeat (3) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
